// File: rtl/edi_string_store_sequencer.sv
// STOS / REP STOS sequencer: stores EAX at EDI, steps EDI by STEP per DF, counts ECX down under REP.
// Latency: 4 cycles per single store, 4N+2 for REP with count N (mem_ack high).
// Backpressure: holds the store request stable in MEM until mem_ack; start is ignored while busy.
module edi_string_store_sequencer #(
    parameter logic [3:0]  EDI_CODE  = 4'h6,
    parameter logic [3:0]  ECX_CODE  = 4'h1,
    parameter logic [3:0]  IDLE_CODE = 4'hF,
    parameter logic [31:0] STEP      = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rep,
    input  logic        dir_flag,
    input  logic [31:0] edi_in,
    input  logic [31:0] ecx_in,
    input  logic [31:0] eax_in,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  read_or_write,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        MEM    = 3'd2,
        WB_EDI = 3'd3,
        WB_ECX = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] edi_q;
    logic [31:0] cnt_q;
    logic [31:0] data_q;
    logic        dir_q;
    logic        rep_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer/count only advance on an accepted store, so CHECK never sees a stale count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edi_q  <= 32'd0;
            cnt_q  <= 32'd0;
            data_q <= 32'd0;
            dir_q  <= 1'b0;
            rep_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        edi_q  <= edi_in;
                        cnt_q  <= ecx_in;
                        data_q <= eax_in;
                        dir_q  <= dir_flag;
                        rep_q  <= rep;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        edi_q <= dir_q ? (edi_q - STEP) : (edi_q + STEP);
                        if (rep_q) begin
                            cnt_q <= cnt_q - 32'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        read_or_write = IDLE_CODE;
        write_data    = 32'd0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // A REP with an exhausted count finishes without touching memory or ECX.
                if (rep_q && (cnt_q == 32'd0)) begin
                    state_d = DONE;
                end else begin
                    state_d = MEM;
                end
            end
            MEM: begin
                mem_req   = 1'b1;
                mem_addr  = edi_q;
                mem_wdata = data_q;
                if (mem_ack) begin
                    state_d = WB_EDI;
                end
            end
            WB_EDI: begin
                read_or_write = EDI_CODE;
                write_data    = edi_q;
                state_d       = rep_q ? WB_ECX : DONE;
            end
            WB_ECX: begin
                read_or_write = ECX_CODE;
                write_data    = cnt_q;
                state_d       = CHECK;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_edi_string_store_sequencer.sv
// Directed bench for edi_string_store_sequencer: single, REP, zero-count, stall, wrap and reset-abort cases.
module tb_edi_string_store_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        rep;
    logic        dir_flag;
    logic [31:0] edi_in;
    logic [31:0] ecx_in;
    logic [31:0] eax_in;
    logic        mem_ack;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  read_or_write;
    logic [31:0] write_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] st_addr[$];
    logic [31:0] st_data[$];
    logic [3:0]  wr_code[$];
    logic [31:0] wr_data[$];
    int          done_k;
    int          ack_k;
    int          edi_wb_k;
    int          stall_bad;
    int          wd_bad;
    int          post_req;
    logic        busy_k1;
    logic        busy_after;

    edi_string_store_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .rep          (rep),
        .dir_flag     (dir_flag),
        .edi_in       (edi_in),
        .ecx_in       (ecx_in),
        .eax_in       (eax_in),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .read_or_write(read_or_write),
        .write_data   (write_data),
        .busy         (busy),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launches one operation and logs stores, register writes and done timing.
    // Cycle k counts negedges after the edge that samples start; mem_ack is driven per MEM cycle.
    task automatic run_op(input logic r, input logic d, input logic [31:0] edi, input logic [31:0] ecx,
                          input logic [31:0] eax, input int stall, input int extra_start_k);
        int          stall_left;
        logic        have_cap;
        logic [31:0] cap_addr;
        logic [31:0] cap_data;
        st_addr.delete(); st_data.delete(); wr_code.delete(); wr_data.delete();
        done_k = -1; ack_k = -1; edi_wb_k = -1;
        stall_bad = 0; wd_bad = 0; post_req = 0;
        busy_k1 = 1'b0; busy_after = 1'b1;
        stall_left = stall; have_cap = 1'b0; cap_addr = 32'd0; cap_data = 32'd0;
        @(negedge clock);
        rep = r; dir_flag = d; edi_in = edi; ecx_in = ecx; eax_in = eax;
        mem_ack = 1'b1; start = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            start = (k == extra_start_k) ? 1'b1 : 1'b0;
            if (start) begin
                edi_in = 32'h5555_0000;
            end
            if (k == 1) busy_k1 = busy;
            if (read_or_write != 4'hF) begin
                wr_code.push_back(read_or_write);
                wr_data.push_back(write_data);
                if (read_or_write == 4'h6 && edi_wb_k < 0) edi_wb_k = k;
            end else if (write_data != 32'd0) begin
                wd_bad++;
            end
            if (done_k >= 0) begin
                if (k == done_k + 1) busy_after = busy;
                if (mem_req) post_req++;
                if (k >= done_k + 3) break;
            end
            if (done && done_k < 0) done_k = k;
            if (mem_req) begin
                if (!have_cap) begin
                    have_cap = 1'b1; cap_addr = mem_addr; cap_data = mem_wdata;
                end else if (mem_addr != cap_addr || mem_wdata != cap_data || read_or_write != 4'hF) begin
                    stall_bad++;
                end
                if (stall_left > 0) begin
                    mem_ack = 1'b0;
                    stall_left--;
                end else begin
                    mem_ack = 1'b1;
                    st_addr.push_back(mem_addr);
                    st_data.push_back(mem_wdata);
                    ack_k = k;
                    have_cap = 1'b0;
                end
            end else begin
                mem_ack = 1'b1;
            end
        end
        start = 1'b0;
        if (done_k < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: no done pulse within budget");
        end
    endtask

    logic [31:0] exp_addr[$];
    logic [3:0]  exp_code[$];
    logic [31:0] exp_wd[$];

    task automatic check_logs(input string tag, input logic [31:0] eax);
        check_val({tag, "_nstores"}, st_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < st_addr.size(); i++) begin
            check_val($sformatf("%s_addr%0d", tag, i), st_addr[i], exp_addr[i]);
            check_val($sformatf("%s_data%0d", tag, i), st_data[i], eax);
        end
        check_val({tag, "_nwrites"}, wr_code.size(), exp_code.size());
        for (int i = 0; i < exp_code.size() && i < wr_code.size(); i++) begin
            check_val($sformatf("%s_code%0d", tag, i), {28'd0, wr_code[i]}, {28'd0, exp_code[i]});
            check_val($sformatf("%s_wdat%0d", tag, i), wr_data[i], exp_wd[i]);
        end
        check_val({tag, "_wd_idle_zero"}, wd_bad, 0);
        check_val({tag, "_busy_k1"}, {31'd0, busy_k1}, 32'd1);
        check_val({tag, "_busy_after_done"}, {31'd0, busy_after}, 32'd0);
        check_val({tag, "_post_req"}, post_req, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; rep = 1'b0; dir_flag = 1'b0;
        edi_in = 32'd0; ecx_in = 32'd0; eax_in = 32'd0; mem_ack = 1'b0;
        #12;
        check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        check_val("rst_rw", {28'd0, read_or_write}, 32'hF);
        check_val("rst_write_data", write_data, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Single store, increment.
        run_op(1'b0, 1'b0, 32'h888, 32'd7, 32'hDEADBEEF, 0, 0);
        exp_addr = '{32'h888};
        exp_code = '{4'h6};
        exp_wd   = '{32'h88C};
        check_logs("single", 32'hDEADBEEF);
        check_val("single_done_k", done_k, 4);

        // REP, decrement, count 3.
        run_op(1'b1, 1'b1, 32'h100, 32'd3, 32'hA5A5_0001, 0, 0);
        exp_addr = '{32'h100, 32'hFC, 32'hF8};
        exp_code = '{4'h6, 4'h1, 4'h6, 4'h1, 4'h6, 4'h1};
        exp_wd   = '{32'hFC, 32'd2, 32'hF8, 32'd1, 32'hF4, 32'd0};
        check_logs("rep3", 32'hA5A5_0001);
        check_val("rep3_done_k", done_k, 14);

        // REP with zero count: nothing but the done pulse.
        run_op(1'b1, 1'b0, 32'h300, 32'd0, 32'h1111_2222, 0, 0);
        exp_addr.delete(); exp_code.delete(); exp_wd.delete();
        check_logs("rep0", 32'h1111_2222);
        check_val("rep0_done_k", done_k, 2);

        // Five-cycle handshake stall.
        run_op(1'b0, 1'b0, 32'h40, 32'd0, 32'h1234_5678, 5, 0);
        exp_addr = '{32'h40};
        exp_code = '{4'h6};
        exp_wd   = '{32'h44};
        check_logs("stall", 32'h1234_5678);
        check_val("stall_stable", stall_bad, 0);
        check_val("stall_ack_k", ack_k, 7);
        check_val("stall_wb_after_ack", edi_wb_k, ack_k + 1);
        check_val("stall_done_k", done_k, 9);

        // Upward wrap, plus a start pulse while busy that must be dropped.
        run_op(1'b0, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'hCAFE_F00D, 0, 2);
        exp_addr = '{32'hFFFF_FFFC};
        exp_code = '{4'h6};
        exp_wd   = '{32'h0};
        check_logs("wrap", 32'hCAFE_F00D);
        check_val("wrap_done_k", done_k, 4);

        // Reset while a store is pending in MEM.
        @(negedge clock);
        rep = 1'b0; dir_flag = 1'b0; edi_in = 32'h200; eax_in = 32'h7777_7777;
        mem_ack = 1'b0; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check_val("abort_in_mem", {31'd0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("abort_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("abort_rw", {28'd0, read_or_write}, 32'hF);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        mem_ack = 1'b1;
        post_req = 0; wd_bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (mem_req) post_req++;
            if (read_or_write != 4'hF) wd_bad++;
        end
        check_val("abort_no_req", post_req, 0);
        check_val("abort_no_write", wd_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/edi_string_store_sequencer.md
Name: edi_string_store_sequencer

Overview:
- Executes STOS / REP STOS: stores EAX to memory at EDI, steps EDI by the element size in the direction given by DF, and counts ECX down under REP.
- Sits upstream of the EDI and ECX register stages: drives the shared read_or_write / write_data register-write bus, so the EDI register captures the updated pointer on code 4'h6.
- Launched by the decode/control stage; talks to memory through a req/ack handshake.

Parameters:
- EDI_CODE, 4'h6, register-write select code for EDI.
- ECX_CODE, 4'h1, register-write select code for ECX.
- IDLE_CODE, 4'hF, select code that writes no register.
- STEP, 32'd4, byte stride per element.

Ports:
- clock  input  1  single system clock; every state change happens on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start  input  1  launch pulse; sampled only in IDLE.
- rep  input  1  1 = REP prefix, 0 = single store.
- dir_flag  input  1  DF; 0 = increment EDI, 1 = decrement EDI.
- edi_in  input  32  current EDI value.
- ecx_in  input  32  current ECX value.
- eax_in  input  32  store data.
- mem_ack  input  1  memory accepted the request.
- mem_req  output  1  store request.
- mem_addr  output  32  store address.
- mem_wdata  output  32  store data.
- read_or_write  output  4  register-write select.
- write_data  output  32  register-write data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, CHECK, MEM, WB_EDI, WB_ECX, DONE.
- Outputs are Moore-style, decoded from the state and the internal registers edi_q, cnt_q, data_q, dir_q and rep_q.
- Reset (reset=0, asynchronous):
  - State goes to IDLE. All internal registers clear to 0.
  - Outputs: mem_req=0, mem_addr=0, mem_wdata=0, read_or_write=IDLE_CODE, write_data=0, busy=0, done=0.
  - Reset mid-operation aborts at once. No further memory or register writes are issued. Writes already issued stand.
- IDLE:
  - On start=1, latch edi_in, ecx_in, eax_in, dir_flag and rep, then go to CHECK.
  - Any start received in other states is ignored (it is not queued).
- CHECK:
  - If rep_q=1 and cnt_q=0, go to DONE. No store and no register write is issued.
  - Otherwise go to MEM.
- MEM:
  - mem_req=1, mem_addr=edi_q, mem_wdata=data_q. These hold stable until mem_ack=1 is sampled.
  - On ack: edi_q <= dir_q ? edi_q-STEP : edi_q+STEP, modulo 2^32, so wrap-around is silent in both directions.
  - On ack with rep_q=1, also cnt_q <= cnt_q-1. Then go to WB_EDI.
  - mem_ack is ignored outside MEM.
- WB_EDI:
  - read_or_write=EDI_CODE, write_data=edi_q, for exactly one cycle.
  - Next state is WB_ECX if rep_q=1, else DONE.
- WB_ECX:
  - read_or_write=ECX_CODE, write_data=cnt_q, for one cycle.
  - Next state is CHECK.
- DONE: done=1 for one cycle, then IDLE. busy falls on the same edge.
- In every state other than WB_EDI and WB_ECX: read_or_write=IDLE_CODE and write_data=0. At most one register write is issued per cycle.
- Latency with mem_ack tied high:
  - Single store: start edge, then CHECK, MEM, WB_EDI, DONE (4 cycles).
  - REP with count N: 4N+2 cycles from leaving IDLE to leaving DONE (CHECK, MEM, WB_EDI and WB_ECX per element, plus the final CHECK and DONE).
- ECX wrap: under REP, cnt_q=0 at start means zero stores. ECX is never decremented past 0.
- The memory write is always issued before the EDI write-back that covers it.

Test Plan:
- Reset: reset=0 while in MEM with mem_req=1 -> mem_req=0, read_or_write=4'hF and busy=0 immediately; after release, no EDI write appears.
- Single store: rep=0, dir=0, edi_in=0x888, eax_in=0xDEADBEEF, mem_ack tied 1 -> one store at 0x888/0xDEADBEEF, then one cycle with read_or_write=4'h6, write_data=0x88C, then done pulse; no ECX write.
- REP with decrement: rep=1, dir=1, edi_in=0x100, ecx_in=3 -> stores to 0x100, 0xFC, 0xF8; EDI writes 0xFC, 0xF8, 0xF4; ECX writes 2, 1, 0; done asserted 14 cycles after start is sampled.
- REP with zero count: rep=1, ecx_in=0 -> no mem_req, no register write, done pulse 2 cycles after start.
- Handshake stall: mem_ack held low for 5 cycles -> mem_req, mem_addr and mem_wdata stay constant and read_or_write stays 4'hF; the EDI write follows the cycle after ack.
- Boundaries: edi_in=0xFFFFFFFC with dir=0 -> EDI write 0x00000000. A start pulse while busy -> ignored, with no extra store.
